universal_shift_register: RTL and testbench

- Parametrised W-bit register built from per-bit flip-flop cells, each with a mode-selected input mux.
- Supports hold, parallel load, clear, logical shift left/right, rotate left/right and arithmetic shift right, plus a registered carry (shifted-out bit) flag.
- Next-generation storage element for the switch/LED lab designs:
  - SW drives d, mode, en and the serial inputs.
  - LEDR displays q and carry.

---
 rtl/usr_pkg.sv | 23 ++
 rtl/usr_bit_cell.sv | 59 +++++
 rtl/universal_shift_register.sv | 106 ++++++++++
 tb/tb_universal_shift_register.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usr_pkg
// Purpose  : Shared definitions for the universal shift register. Holds the
//            3-bit operation-select encodings and the mode_t type used on
//            the mode ports.
// Revision : 1.0 - initial release
// ============================================================================
package usr_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD  = 3'b000;
    localparam mode_t MODE_LOAD  = 3'b001;
    localparam mode_t MODE_CLEAR = 3'b010;
    localparam mode_t MODE_SHL   = 3'b011;
    localparam mode_t MODE_SHR   = 3'b100;
    localparam mode_t MODE_ROL   = 3'b101;
    localparam mode_t MODE_ROR   = 3'b110;
    localparam mode_t MODE_ASR   = 3'b111;

endpackage : usr_pkg
`default_nettype wire

// File: rtl/usr_bit_cell.sv
`default_nettype none
// ============================================================================
// Module   : usr_bit_cell
// Purpose  : One storage bit of the universal shift register: a flip-flop
//            with synchronous active-low reset, clock enable and an 8:1
//            mode-selected input mux.
// Ports    : clk       - rising-edge clock
//            resetn    - synchronous active-low reset (priority over en)
//            en        - clock enable; 0 holds the bit for any mode
//            mode      - operation select
//            nbr_left  - next-more-significant bit (feeds SHR/ROR/ASR)
//            nbr_right - next-less-significant bit (feeds SHL/ROL)
//            d_bit     - parallel load bit
//            q         - stored bit
// Revision : 1.0 - initial release
// ============================================================================
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  logic  en,
    input  mode_t mode,
    input  logic  nbr_left,
    input  logic  nbr_right,
    input  logic  d_bit,
    output logic  q
);

    logic bit_d;
    logic bit_q;

    always_comb begin
        bit_d = bit_q;
        case (mode)
            MODE_HOLD:  bit_d = bit_q;
            MODE_LOAD:  bit_d = d_bit;
            MODE_CLEAR: bit_d = 1'b0;
            MODE_SHL:   bit_d = nbr_right;
            MODE_SHR:   bit_d = nbr_left;
            MODE_ROL:   bit_d = nbr_right;
            MODE_ROR:   bit_d = nbr_left;
            MODE_ASR:   bit_d = nbr_left;
            default:    bit_d = bit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bit_q <= 1'b0;
        end else if (en) begin
            bit_q <= bit_d;
        end
    end

    assign q = bit_q;

endmodule : usr_bit_cell
`default_nettype wire

// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_register
// Purpose  : W-bit universal register: hold, load, clear, logical shift
//            left/right, rotate left/right and arithmetic shift right, with
//            a registered carry holding the last bit shifted/rotated out.
// Ports    : clk      - rising-edge clock
//            resetn   - synchronous active-low reset
//            en       - clock enable; 0 holds q and carry for any mode
//            mode     - operation select (usr_pkg MODE_* encodings)
//            d        - parallel load data
//            sin_lsb  - serial bit entering bit 0 on SHL
//            sin_msb  - serial bit entering bit W-1 on SHR
//            q        - register contents
//            carry    - registered shifted/rotated-out bit
//            sout_msb - combinational copy of q[W-1]
//            sout_lsb - combinational copy of q[0]
// Revision : 1.0 - initial release
// ============================================================================
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    input  logic [2:0]   mode,
    input  logic [W-1:0] d,
    input  logic         sin_lsb,
    input  logic         sin_msb,
    output logic [W-1:0] q,
    output logic         carry,
    output logic         sout_msb,
    output logic         sout_lsb
);

    logic [W-1:0] nbr_left;
    logic [W-1:0] nbr_right;
    logic         carry_d;
    logic         carry_q;

    // Neighbour routing. Interior bits simply see their neighbours; only the
    // two end bits depend on the mode (serial input versus wrap-around/sign).
    // For W=1 both ends are the same cell, which gives q unchanged on
    // ROL/ROR/ASR without any special casing.
    always_comb begin
        nbr_left  = '0;
        nbr_right = '0;

        nbr_right[0] = (mode == MODE_SHL) ? sin_lsb : q[W-1];
        for (int i = 1; i < W; i++) begin
            nbr_right[i] = q[i-1];
        end

        for (int i = 0; i < W - 1; i++) begin
            nbr_left[i] = q[i+1];
        end
        case (mode)
            MODE_SHR: nbr_left[W-1] = sin_msb;
            MODE_ASR: nbr_left[W-1] = q[W-1];
            default:  nbr_left[W-1] = q[0];
        endcase
    end

    generate
        for (genvar g = 0; g < W; g++) begin : g_cell
            usr_bit_cell u_cell (
                .clk       (clk),
                .resetn    (resetn),
                .en        (en),
                .mode      (mode),
                .nbr_left  (nbr_left[g]),
                .nbr_right (nbr_right[g]),
                .d_bit     (d[g]),
                .q         (q[g])
            );
        end
    endgenerate

    // Left-moving operations eject the MSB, right-moving ones eject the LSB.
    always_comb begin
        carry_d = carry_q;
        case (mode)
            MODE_HOLD:            carry_d = carry_q;
            MODE_LOAD,
            MODE_CLEAR:           carry_d = 1'b0;
            MODE_SHL, MODE_ROL:   carry_d = q[W-1];
            default:              carry_d = q[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            carry_q <= 1'b0;
        end else if (en) begin
            carry_q <= carry_d;
        end
    end

    assign carry    = carry_q;
    assign sout_msb = q[W-1];
    assign sout_lsb = q[0];

endmodule : universal_shift_register
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_universal_shift_register
// Purpose  : Self-checking bench for universal_shift_register: a vector
//            table for the 8-bit instance, plus hand-written sequences for
//            the asynchronous-pulse case, a chained pair of 4-bit instances
//            and a 1-bit instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_CLEAR = 3'b010;
    localparam logic [2:0] M_SHL   = 3'b011;
    localparam logic [2:0] M_SHR   = 3'b100;
    localparam logic [2:0] M_ROL   = 3'b101;
    localparam logic [2:0] M_ROR   = 3'b110;
    localparam logic [2:0] M_ASR   = 3'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- 8-bit instance ----------------
    logic       rn8 = 1'b0, en8 = 1'b0, sl8 = 1'b0, sm8 = 1'b0;
    logic [2:0] md8 = 3'b000;
    logic [7:0] d8  = 8'h00;
    logic [7:0] q8;
    logic       c8, so_msb8, so_lsb8;

    universal_shift_register #(.W(8)) u_dut8 (
        .clk(clk), .resetn(rn8), .en(en8), .mode(md8), .d(d8),
        .sin_lsb(sl8), .sin_msb(sm8), .q(q8), .carry(c8),
        .sout_msb(so_msb8), .sout_lsb(so_lsb8)
    );

    // ---------------- chained 4-bit pair ----------------
    logic       rn4 = 1'b0, en4 = 1'b0, sl4 = 1'b0, sm4 = 1'b0;
    logic [2:0] md4 = 3'b000;
    logic [3:0] d4lo = 4'h0, d4hi = 4'h0;
    logic [3:0] q4lo, q4hi;
    logic       c4lo, c4hi, lo_msb, lo_lsb, hi_msb, hi_lsb;

    universal_shift_register #(.W(4)) u_lo (
        .clk(clk), .resetn(rn4), .en(en4), .mode(md4), .d(d4lo),
        .sin_lsb(sl4), .sin_msb(sm4), .q(q4lo), .carry(c4lo),
        .sout_msb(lo_msb), .sout_lsb(lo_lsb)
    );

    universal_shift_register #(.W(4)) u_hi (
        .clk(clk), .resetn(rn4), .en(en4), .mode(md4), .d(d4hi),
        .sin_lsb(lo_msb), .sin_msb(sm4), .q(q4hi), .carry(c4hi),
        .sout_msb(hi_msb), .sout_lsb(hi_lsb)
    );

    // ---------------- 1-bit instance ----------------
    logic       rn1 = 1'b0, en1 = 1'b0, sl1 = 1'b0, sm1 = 1'b0;
    logic [2:0] md1 = 3'b000;
    logic [0:0] d1  = 1'b0;
    logic [0:0] q1;
    logic       c1, so_msb1, so_lsb1;

    universal_shift_register #(.W(1)) u_dut1 (
        .clk(clk), .resetn(rn1), .en(en1), .mode(md1), .d(d1),
        .sin_lsb(sl1), .sin_msb(sm1), .q(q1), .carry(c1),
        .sout_msb(so_msb1), .sout_lsb(so_lsb1)
    );

    typedef struct {
        logic       rn;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sl;
        logic       sm;
        logic [7:0] eq;
        logic       ec;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rn, input logic en, input logic [2:0] mode,
                       input logic [7:0] d, input logic sl, input logic sm,
                       input logic [7:0] eq, input logic ec);
        vec_t v;
        v.rn = rn; v.en = en; v.mode = mode; v.d = d;
        v.sl = sl; v.sm = sm; v.eq = eq; v.ec = ec;
        vq.push_back(v);
    endtask

    task automatic step1(input logic [2:0] mode, input logic d, input logic sl,
                         input logic sm, input logic eq, input logic ec, input string name);
        @(negedge clk);
        rn1 = 1'b1; en1 = 1'b1; md1 = mode; d1 = d; sl1 = sl; sm1 = sm;
        @(posedge clk); #1;
        check({name, "_q"}, {31'd0, q1[0]}, {31'd0, eq});
        check({name, "_carry"}, {31'd0, c1}, {31'd0, ec});
        check({name, "_sout"}, {30'd0, so_msb1, so_lsb1}, {30'd0, eq, eq});
    endtask

    initial begin
        // Vector table: {resetn, en, mode, d, sin_lsb, sin_msb, exp q, exp carry}
        add(0, 0, M_HOLD,  8'h00, 0, 0, 8'h00, 0);  // reset state
        add(1, 1, M_LOAD,  8'hA5, 0, 0, 8'hA5, 0);
        add(0, 1, M_LOAD,  8'hA5, 0, 0, 8'h00, 0);  // reset wins over en/mode
        add(1, 1, M_LOAD,  8'h3C, 0, 0, 8'h3C, 0);  // load accepted after reset
        add(1, 0, M_CLEAR, 8'h00, 0, 0, 8'h3C, 0);
        add(1, 0, M_CLEAR, 8'h00, 0, 0, 8'h3C, 0);
        add(1, 0, M_CLEAR, 8'h00, 0, 0, 8'h3C, 0);
        add(1, 1, M_HOLD,  8'hFF, 1, 1, 8'h3C, 0);
        add(1, 1, M_LOAD,  8'h81, 0, 0, 8'h81, 0);
        add(1, 1, M_SHL,   8'h00, 1, 0, 8'h03, 1);
        add(1, 1, M_SHR,   8'h00, 0, 0, 8'h01, 1);
        add(1, 1, M_SHR,   8'h00, 0, 0, 8'h00, 1);
        add(1, 1, M_SHR,   8'h00, 0, 0, 8'h00, 0);
        add(1, 1, M_LOAD,  8'h81, 0, 0, 8'h81, 0);
        add(1, 1, M_ROL,   8'h00, 0, 0, 8'h03, 1);
        add(1, 1, M_ROR,   8'h00, 0, 0, 8'h81, 1);
        add(1, 1, M_ROR,   8'h00, 0, 0, 8'hC0, 1);
        add(1, 1, M_LOAD,  8'h90, 0, 0, 8'h90, 0);
        add(1, 1, M_ASR,   8'h00, 0, 0, 8'hC8, 0);
        add(1, 1, M_SHL,   8'h00, 0, 1, 8'h90, 1);
        add(1, 1, M_CLEAR, 8'hFF, 1, 1, 8'h00, 0);
        add(1, 1, M_LOAD,  8'hFF, 0, 0, 8'hFF, 0);
        add(1, 1, M_ASR,   8'h00, 0, 0, 8'hFF, 1);
        add(1, 1, M_SHR,   8'h00, 0, 1, 8'hFF, 1);
        add(1, 1, M_HOLD,  8'h00, 0, 0, 8'hFF, 1);
        add(1, 0, M_SHL,   8'h00, 0, 0, 8'hFF, 1);
        add(1, 1, M_SHL,   8'h00, 0, 0, 8'hFE, 1);
        add(1, 1, M_ROR,   8'h00, 0, 0, 8'h7F, 0);

        // Initial reset of every instance.
        @(negedge clk);
        rn8 = 1'b0; rn4 = 1'b0; rn1 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("w1_reset_q", {31'd0, q1[0]}, 32'd0);
        check("w1_reset_carry", {31'd0, c1}, 32'd0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rn8 = vq[i].rn; en8 = vq[i].en; md8 = vq[i].mode;
            d8 = vq[i].d; sl8 = vq[i].sl; sm8 = vq[i].sm;
            @(posedge clk); #1;
            check($sformatf("vec%0d_q", i), {24'd0, q8}, {24'd0, vq[i].eq});
            check($sformatf("vec%0d_carry", i), {31'd0, c8}, {31'd0, vq[i].ec});
            check($sformatf("vec%0d_sout", i), {30'd0, so_msb8, so_lsb8},
                  {30'd0, vq[i].eq[7], vq[i].eq[0]});
        end

        // A resetn pulse that starts and ends between edges must be ignored.
        @(negedge clk);
        rn8 = 1'b1; en8 = 1'b1; md8 = M_LOAD; d8 = 8'h5A;
        @(posedge clk); #1;
        check("pulse_pre_q", {24'd0, q8}, 32'h5A);
        @(negedge clk);
        en8 = 1'b0; md8 = M_HOLD;
        #1 rn8 = 1'b0;
        #2 rn8 = 1'b1;
        @(posedge clk); #1;
        check("pulse_post_q", {24'd0, q8}, 32'h5A);

        // Chained pair: low half loaded 0, high half 8, shift left 4 times.
        @(negedge clk);
        rn4 = 1'b1; en4 = 1'b1; md4 = M_LOAD; d4lo = 4'h0; d4hi = 4'h8;
        @(posedge clk); #1;
        check("chain_load", {24'd0, q4hi, q4lo}, 32'h80);
        begin
            logic [7:0] exp_lo [4];
            logic [7:0] exp_hi [4];
            logic       exp_hc [4];
            exp_lo = '{8'h1, 8'h3, 8'h7, 8'hF};
            exp_hi = '{8'h0, 8'h0, 8'h0, 8'h0};
            exp_hc = '{1'b1, 1'b0, 1'b0, 1'b0};
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                md4 = M_SHL; sl4 = 1'b1;
                @(posedge clk); #1;
                check($sformatf("chain%0d_lo", k), {28'd0, q4lo}, {24'd0, exp_lo[k]});
                check($sformatf("chain%0d_hi", k), {28'd0, q4hi}, {24'd0, exp_hi[k]});
                check($sformatf("chain%0d_hi_carry", k), {31'd0, c4hi}, {31'd0, exp_hc[k]});
            end
        end

        // One-bit instance boundary behaviour.
        step1(M_LOAD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "w1_load");
        step1(M_SHL,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "w1_shl");
        step1(M_ROL,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "w1_rol");
        step1(M_SHR,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "w1_shr");
        step1(M_ROR,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "w1_ror");
        step1(M_ASR,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "w1_asr");
        step1(M_SHR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "w1_shr0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_universal_shift_register
`default_nettype wire
